meas_frame_packer: RTL

Downstream stage of the frequency-meter datapath. It snapshots the gated measurement results (Num_x, Num_s, cnt_high, cnt_low) when the real gate closes, then serialises them into a fixed 20-byte frame. The frame is streamed byte-by-byte over a valid/ready interface into the UART transmitter.

---
 rtl/meas_frame_packer_if.sv | 11 +
 rtl/meas_frame_packer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/meas_frame_packer_if.sv
// Byte stream from the frame packer to the UART transmitter.
// A byte moves on every clock edge where tx_valid and tx_ready are both high.
interface meas_frame_packer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  // The packer drives data and valid; the UART drives ready.
  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/meas_frame_packer.sv
// Frequency-meter frame packer.
// When the measurement gate closes, the module takes a snapshot of the counts.
// It then streams a fixed 20-byte frame:
//   AA 55 seq Num_x[4] Num_s[4] cnt_high[4] cnt_low[4] checksum
// Each word is sent MSB first.
// The checksum is the 8-bit sum of the bytes from seq up to the last byte of cnt_low.
module meas_frame_packer #(
  parameter logic [7:0] HDR0  = 8'hAA,
  parameter logic [7:0] HDR1  = 8'h55,
  parameter int         NUM_W = 28
) (
  input  logic                 Sys_CLK,
  input  logic                 Sys_RST,
  input  logic                 gate,
  input  logic [NUM_W-1:0]     Num_x,
  input  logic [NUM_W-1:0]     Num_s,
  input  logic [31:0]          cnt_high,
  input  logic [31:0]          cnt_low,
  meas_frame_packer_if.master  tx,
  output logic                 busy,
  output logic                 frame_drop,
  output logic [7:0]           seq
);

  localparam logic [4:0] LAST_IDX = 5'd19;

  typedef enum logic [0:0] {IDLE, SEND} state_t;

  state_t       state_q;
  logic         g1_q, g2_q, g3_q;
  logic [127:0] payload_q;
  logic [7:0]   seq_snap_q;
  logic [4:0]   idx_q;
  logic [7:0]   csum_q;
  logic [7:0]   tx_data_q;
  logic         tx_valid_q;
  logic         busy_q;
  logic         drop_q;
  logic [7:0]   seq_q;

  logic         gate_close;
  logic [4:0]   idx_d;
  logic [7:0]   csum_d;
  logic [7:0]   byte_d;
  logic [3:0]   pidx;
  logic [7:0]   payload_bytes [16];

  // A gate close is the falling edge of the synchronised gate,
  // seen one flop behind the synchroniser.
  assign gate_close = g3_q & ~g2_q;

  // Split the snapshot into bytes, MSB first, so the mux below can index them.
  for (genvar gi = 0; gi < 16; gi++) begin : g_payload
    assign payload_bytes[gi] = payload_q[127-8*gi -: 8];
  end

  // Index 3 maps to payload byte 0.
  // The subtraction wraps modulo 16, which is correct for indices 3..18.
  assign pidx = idx_d[3:0] - 4'd3;

  // Work out the byte that follows the one on the bus,
  // and the running checksum once the current byte has been accepted.
  always_comb begin
    idx_d  = idx_q + 5'd1;
    csum_d = csum_q;
    if (idx_q >= 5'd2 && idx_q <= 5'd18)
      csum_d = csum_q + tx_data_q;
    case (idx_d)
      5'd1:    byte_d = HDR1;
      5'd2:    byte_d = seq_snap_q;
      5'd19:   byte_d = csum_d;
      5'd0:    byte_d = HDR0;
      default: byte_d = payload_bytes[pidx];
    endcase
  end

  // The gate comes from another clock domain.
  // Two synchroniser flops, plus a delay flop for edge detection.
  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      g1_q <= 1'b0;
      g2_q <= 1'b0;
      g3_q <= 1'b0;
    end else begin
      g1_q <= gate;
      g2_q <= g1_q;
      g3_q <= g2_q;
    end
  end

  // Frame FSM: snapshot on the gate close, stream the bytes, drop gate closes while busy.
  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      state_q    <= IDLE;
      payload_q  <= '0;
      seq_snap_q <= '0;
      idx_q      <= '0;
      csum_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
      seq_q      <= '0;
    end else begin
      drop_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gate_close) begin
            // The first byte is valid on the same edge that takes the snapshot.
            payload_q  <= {{(32-NUM_W){1'b0}}, Num_x,
                           {(32-NUM_W){1'b0}}, Num_s,
                           cnt_high, cnt_low};
            seq_snap_q <= seq_q;
            idx_q      <= '0;
            csum_q     <= '0;
            tx_data_q  <= HDR0;
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= SEND;
          end
        end
        SEND: begin
          // This includes a gate close on the edge that ends the frame.
          if (gate_close)
            drop_q <= 1'b1;
          if (tx_valid_q && tx.tx_ready) begin
            if (idx_q == LAST_IDX) begin
              tx_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              seq_q      <= seq_q + 8'd1;
              state_q    <= IDLE;
            end else begin
              idx_q     <= idx_d;
              csum_q    <= csum_d;
              tx_data_q <= byte_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign busy        = busy_q;
  assign frame_drop  = drop_q;
  assign seq         = seq_q;

endmodule
